// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// and drives every datapath mux, write enable and the ALU operation code.
module mc_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       irwrite,
    output logic       pcen,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
    } ctrl_t;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic ctrl_t decode(input state_t s, input logic [5:0] f);
        ctrl_t c;
        c            = '0;
        c.alucontrol = 3'b010;
        case (s)
            FETCH: begin
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.alusrcb = 2'b01;
            end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            EXECUTE: begin
                c.alusrca    = 1'b1;
                c.alucontrol = funct_alu(f);
            end
            ALUWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            ADDIWB:  c.regwrite = 1'b1;
            BEQEX: begin
                c.alusrca    = 1'b1;
                c.alucontrol = 3'b110;
                c.pcsrc      = 2'b01;
                c.branch     = 1'b1;
            end
            JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  ctrl_q;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = funct_legal(funct) ? EXECUTE : FETCH;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ctrl_q  <= decode(FETCH, 6'b000000);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d, funct);
        end
    end

    // Write enables are held off asynchronously so nothing pulses during reset.
    assign irwrite    = rst_n & ctrl_q.irwrite;
    assign pcen       = rst_n & (ctrl_q.pcwrite | (ctrl_q.branch & zero));
    assign memwrite   = rst_n & ctrl_q.memwrite;
    assign regwrite   = rst_n & ctrl_q.regwrite;
    assign iord       = ctrl_q.iord;
    assign regdst     = ctrl_q.regdst;
    assign memtoreg   = ctrl_q.memtoreg;
    assign alusrca    = ctrl_q.alusrca;
    assign alusrcb    = ctrl_q.alusrcb;
    assign pcsrc      = ctrl_q.pcsrc;
    assign alucontrol = ctrl_q.alucontrol;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through its
// state sequence and checks every control output in every visited state.
module tb_mc_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       irwrite, pcen, memwrite, regwrite, iord, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_seq[$];

    mc_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Packed view: {irwrite,pcen,memwrite,regwrite,iord,regdst,memtoreg,alusrca,alusrcb,pcsrc,alucontrol}
    function automatic logic [14:0] exp_outs(input int s, input logic [5:0] f, input logic z);
        logic [2:0] fa;
        case (f)
            6'b100000: fa = 3'b010;
            6'b100010: fa = 3'b110;
            6'b100100: fa = 3'b000;
            6'b100101: fa = 3'b001;
            6'b101010: fa = 3'b111;
            default:   fa = 3'b010;
        endcase
        case (s)
            0:  return {8'b1100_0000, 2'b01, 2'b00, 3'b010};
            1:  return {8'b0000_0000, 2'b11, 2'b00, 3'b010};
            2:  return {8'b0000_0001, 2'b10, 2'b00, 3'b010};
            3:  return {8'b0000_1000, 2'b00, 2'b00, 3'b010};
            4:  return {8'b0001_0010, 2'b00, 2'b00, 3'b010};
            5:  return {8'b0010_1000, 2'b00, 2'b00, 3'b010};
            6:  return {8'b0000_0001, 2'b00, 2'b00, fa};
            7:  return {8'b0001_0100, 2'b00, 2'b00, 3'b010};
            8:  return {1'b0, z, 6'b00_0001, 2'b00, 2'b01, 3'b110};
            9:  return {8'b0000_0001, 2'b10, 2'b00, 3'b010};
            10: return {8'b0001_0000, 2'b00, 2'b00, 3'b010};
            11: return {8'b0100_0000, 2'b00, 2'b10, 3'b010};
            default: return {8'b0000_0000, 2'b00, 2'b00, 3'b010};
        endcase
    endfunction

    function automatic logic [14:0] outs();
        return {irwrite, pcen, memwrite, regwrite, iord, regdst, memtoreg, alusrca,
                alusrcb, pcsrc, alucontrol};
    endfunction

    // Entered sampled in FETCH; leaves sampled in the following FETCH.
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                             input logic z);
        op    = o;
        funct = f;
        zero  = z;
        for (int i = 0; i < exp_seq.size(); i++) begin
            check($sformatf("%s state[%0d]", tag, i), 32'(state), 32'(exp_seq[i]));
            check($sformatf("%s outs@%0d", tag, exp_seq[i]), 32'(outs()),
                  32'(exp_outs(exp_seq[i], f, z)));
            @(posedge clk);
            #1;
        end
        check({tag, " return"}, 32'(state), 32'd0);
    endtask

    task automatic abort_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, " state"},    32'(state),    32'd0);
        check({tag, " memwrite"}, 32'(memwrite), 32'd0);
        check({tag, " regwrite"}, 32'(regwrite), 32'd0);
        check({tag, " irwrite"},  32'(irwrite),  32'd0);
        check({tag, " pcen"},     32'(pcen),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        op    = 6'b000000;
        funct = 6'b000000;
        zero  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst state",    32'(state),    32'd0);
        check("rst irwrite",  32'(irwrite),  32'd0);
        check("rst pcen",     32'(pcen),     32'd0);
        check("rst memwrite", 32'(memwrite), 32'd0);
        check("rst regwrite", 32'(regwrite), 32'd0);
        check("rst alusrcb",  32'(alusrcb),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel irwrite", 32'(irwrite), 32'd1);
        check("rel pcen",    32'(pcen),    32'd1);
        check("rel alusrcb", 32'(alusrcb), 32'd1);

        exp_seq = '{0, 1, 2, 3, 4};
        run_instr("lw", 6'b100011, 6'b000000, 1'b0);

        exp_seq = '{0, 1, 6, 7};
        run_instr("slt", 6'b000000, 6'b101010, 1'b0);
        run_instr("add", 6'b000000, 6'b100000, 1'b0);
        run_instr("sub", 6'b000000, 6'b100010, 1'b0);
        run_instr("and", 6'b000000, 6'b100100, 1'b0);
        run_instr("or",  6'b000000, 6'b100101, 1'b0);

        exp_seq = '{0, 1, 8};
        run_instr("beq z1", 6'b000100, 6'b000000, 1'b1);
        run_instr("beq z0", 6'b000100, 6'b000000, 1'b0);

        exp_seq = '{0, 1};
        run_instr("illegal op", 6'b111111, 6'b000000, 1'b0);
        run_instr("illegal funct", 6'b000000, 6'b000000, 1'b0);

        exp_seq = '{0, 1, 2, 5};
        run_instr("sw", 6'b101011, 6'b000000, 1'b0);

        exp_seq = '{0, 1, 9, 10};
        run_instr("addi", 6'b001000, 6'b000000, 1'b0);

        exp_seq = '{0, 1, 11};
        run_instr("j", 6'b000010, 6'b000000, 1'b0);

        op    = 6'b101011;
        funct = 6'b000000;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("sw mid state",    32'(state),    32'd5);
        check("sw mid memwrite", 32'(memwrite), 32'd1);
        abort_check("abort MEMWR");

        op    = 6'b000000;
        funct = 6'b100000;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("add mid state",    32'(state),    32'd7);
        check("add mid regwrite", 32'(regwrite), 32'd1);
        abort_check("abort ALUWB");

        exp_seq = '{0, 1, 2, 3, 4};
        run_instr("lw after abort", 6'b100011, 6'b000000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the single-ported-memory MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath mux and write enable, and generates the 3-bit `alucontrol` consumed by the ALU. It takes the ALU `zero` flag back in to resolve `beq`.

## Interface

Parameters:
- none; opcode, funct and state encodings are fixed below.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  6  instruction[31:26] from the instruction register; stable from DECODE onward.
- `funct`  in  6  instruction[5:0] from the instruction register.
- `zero`  in  1  ALU zero flag; same-cycle combinational input.
- `irwrite`  out  1  load instruction register.
- `pcen`  out  1  PC load enable, equal to `pcwrite | (branch & zero)`.
- `memwrite`  out  1  memory write strobe.
- `regwrite`  out  1  register-file write.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `regdst`  out  1  write-register select: 0 = rt, 1 = rd.
- `memtoreg`  out  1  writeback data select: 0 = ALUOut, 1 = memory data.
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = register A.
- `alusrcb`  out  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- `pcsrc`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol`  out  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `state`  out  4  current state, exported for debug.

## Operation

Opcodes:
- R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.

R-type funct mapping:
- add 100000 -> 010; sub 100010 -> 110; and 100100 -> 000; or 100101 -> 001; slt 101010 -> 111.

State encodings and transitions:
- FETCH 0 -> DECODE.
- DECODE 1 -> MEMADR (lw or sw), EXECUTE (R-type with a legal funct), BEQEX, ADDIEX or JEX.
- DECODE goes back to FETCH for an unknown opcode or an illegal R-type funct. The instruction is dropped with no register, memory or PC write beyond the fetch increment.
- MEMADR 2 -> MEMRD (lw) or MEMWR (sw).
- MEMRD 3 -> MEMWB 4 -> FETCH.
- MEMWR 5 -> FETCH.
- EXECUTE 6 -> ALUWB 7 -> FETCH.
- BEQEX 8 -> FETCH.
- ADDIEX 9 -> ADDIWB 10 -> FETCH.
- JEX 11 -> FETCH.
- Encodings 12-15 are unreachable. If entered, the next state is FETCH and all outputs take their defaults.

Per-state outputs (anything not listed is 0; `alucontrol` defaults to 010):
- FETCH: `irwrite`=1, `pcwrite`=1, `alusrcb`=01, `alucontrol`=010.
- DECODE: `alusrcb`=11, `alucontrol`=010 (branch target precomputed into ALUOut).
- MEMADR and ADDIEX: `alusrca`=1, `alusrcb`=10, `alucontrol`=010.
- MEMRD: `iord`=1.
- MEMWR: `iord`=1, `memwrite`=1.
- MEMWB: `regwrite`=1, `memtoreg`=1.
- EXECUTE: `alusrca`=1, `alusrcb`=00, `alucontrol` from funct.
- ALUWB: `regwrite`=1, `regdst`=1.
- ADDIWB: `regwrite`=1.
- BEQEX: `alusrca`=1, `alusrcb`=00, `alucontrol`=110, `pcsrc`=01, `branch`=1.
- JEX: `pcsrc`=10, `pcwrite`=1.

Output structure:
- All outputs are Moore decodes of the state register.
- The only exception is `pcen`, which combines the state decode with `zero`.

## Timing

Reset:
- `rst_n` low forces `state`=FETCH immediately, without waiting for a clock edge.
- While `rst_n` is low, `irwrite`, `pcen`, `memwrite` and `regwrite` are forced to 0. All other outputs show their FETCH values.
- The first active FETCH cycle is the first rising edge after `rst_n` deasserts.

Cycles per instruction, counted FETCH through the last state:
- lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.

Same-cycle behaviour:
- `pcen` in BEQEX follows `zero` within the same cycle. `zero` must settle before the clock edge.

Reset mid-instruction:
- Asserting reset during any state aborts the instruction. No write enable may pulse after `rst_n` falls.

## Test plan

- Reset: hold `rst_n`=0 across 3 edges -> `state`=0, `irwrite`=`pcen`=`memwrite`=`regwrite`=0. Release -> next cycle `irwrite`=1, `pcen`=1, `alusrcb`=01.
- lw (`op`=100011) -> state sequence 0,1,2,3,4,0. In state 3, `iord`=1. In state 4, `regwrite`=1 and `memtoreg`=1. Total 5 cycles.
- R-type slt (`funct`=101010) -> states 0,1,6,7,0 with `alucontrol`=111 in state 6. In state 7, `regwrite`=1 and `regdst`=1. Repeat for add, sub, and, or -> 010, 110, 000, 001.
- beq (`op`=000100): with `zero`=1 in BEQEX -> `pcen`=1, `pcsrc`=01, `alucontrol`=110. With `zero`=0 -> `pcen`=0. Both cases return to state 0 after 3 cycles.
- Illegal op 111111, then R-type with funct 000000 -> each runs states 0,1,0 with no `regwrite` or `memwrite`. sw runs states 0,1,2,5,0 with `memwrite`=1 only in state 5.
- Reset asserted mid-cycle in MEMWR and in ALUWB -> `memwrite` and `regwrite` drop to 0 asynchronously and `state`=0 before the next edge.
